// File: rtl/csr_trap_pkg.sv
// ---------------------------------------------------------------------------
// csr_trap_pkg
// Shared types and constants for the CSR trap controller:
//   trap_state_e   - controller state (IDLE / PENDING / FLUSH)
//   CAUSE_READ     - trap cause code for a read violation  (2'b01)
//   CAUSE_WRITE    - trap cause code for a write violation (2'b10)
//   MACHINE_PRIV   - encoding of the machine privilege level (2'b11)
//   cause_of()     - maps the access direction to its cause code
// ---------------------------------------------------------------------------
package csr_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_FLUSH   = 2'b10
  } trap_state_e;

  localparam logic [1:0] CAUSE_READ   = 2'b01;
  localparam logic [1:0] CAUSE_WRITE  = 2'b10;
  localparam logic [1:0] MACHINE_PRIV = 2'b11;

  // A write violation takes precedence when read and write coincide.
  function automatic logic [1:0] cause_of(input logic is_write);
    return is_write ? CAUSE_WRITE : CAUSE_READ;
  endfunction

endpackage

// File: rtl/trap_log_fifo.sv
// ---------------------------------------------------------------------------
// trap_log_fifo
// Synchronous FIFO recording faulting CSR addresses. Only compiled when the
// CSR_TRAP_LOG_EN macro is defined. All outputs are registered.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   i_push, i_data    - write request and data
//   i_pop             - remove head entry (ignored when empty)
//   o_valid           - FIFO not empty
//   o_data            - head entry (0 when empty)
//   o_full            - FIFO holds DEPTH entries
//   o_drop            - combinational: push refused because FIFO is full
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
`ifdef CSR_TRAP_LOG_EN
module trap_log_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [PW:0]       r_cnt;
  logic              r_valid;
  logic              r_full;
  logic [DATA_W-1:0] r_head;

  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;
  logic [PW:0]       w_cnt_pop;
  logic [PW:0]       w_cnt_nxt;
  logic [PW-1:0]     w_rd_nxt;
  logic [DATA_W-1:0] w_head_nxt;

  assign w_full    = (r_cnt == FULL_CNT);
  assign w_do_pop  = i_pop & (r_cnt != CNT_ZERO);
  // A pop in the same cycle frees the slot, so a push on a full FIFO proceeds.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_drop    = i_push & w_full & ~w_do_pop;

  assign w_cnt_pop = w_do_pop  ? (r_cnt - CNT_ONE)     : r_cnt;
  assign w_cnt_nxt = w_do_push ? (w_cnt_pop + CNT_ONE) : w_cnt_pop;
  assign w_rd_nxt  = w_do_pop  ? (r_rd + PTR_ONE)      : r_rd;

  // Next head value: the bypassed push when the FIFO would otherwise be empty.
  always_comb begin
    w_head_nxt = {DATA_W{1'b0}};
    if (w_cnt_pop == CNT_ZERO) begin
      if (w_do_push) begin
        w_head_nxt = i_data;
      end else begin
        w_head_nxt = {DATA_W{1'b0}};
      end
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers, occupancy and registered status/head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= {PW{1'b0}};
      r_rd    <= {PW{1'b0}};
      r_cnt   <= CNT_ZERO;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_head  <= {DATA_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + PTR_ONE;
      end
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != CNT_ZERO);
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_head  <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_full  = r_full;

endmodule
`endif

// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
// Trap controller behind the CSR privilege check. A faulting access seen in
// IDLE is captured and held as a trap request until the core acknowledges it,
// then a one-cycle flush is issued. Faults arriving while busy are dropped and
// flagged in a sticky overrun bit. Accepted traps are counted (saturating).
// Optional feature macro: CSR_TRAP_LOG_EN adds a LOG_DEPTH-entry address log;
// without it the log port reads as zero and log_pop is ignored.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   read, write, except          - CSR access and privilege-check result
//   priv_state, address          - privilege and CSR address of the access
//   trap_ack                     - core accepts the pending trap
//   clr_overrun                  - clears trap_overrun (a same-cycle set wins)
//   trap_req, trap_cause,
//   trap_addr, trap_priv         - pending trap and its captured fields
//   stall, flush                 - pipeline control
//   trap_overrun, trap_count     - sticky lost-fault flag, accepted traps
//   log_pop/log_valid/
//   log_addr/log_full            - trap log read port
// All outputs are registered.
// ---------------------------------------------------------------------------
module csr_trap_ctrl
  import csr_trap_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int CNT_W     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [1:0]        priv_state,
  input  logic [ADDR_W-1:0] address,
  input  logic              except,
  input  logic              trap_ack,
  input  logic              clr_overrun,
  output logic              trap_req,
  output logic [1:0]        trap_cause,
  output logic [ADDR_W-1:0] trap_addr,
  output logic [1:0]        trap_priv,
  output logic              stall,
  output logic              flush,
  output logic              trap_overrun,
  output logic [CNT_W-1:0]  trap_count,
  input  logic              log_pop,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic              log_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  trap_state_e       r_state;
  logic              r_trap_req;
  logic [1:0]        r_trap_cause;
  logic [ADDR_W-1:0] r_trap_addr;
  logic [1:0]        r_trap_priv;
  logic              r_stall;
  logic              r_flush;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_count;

  logic              w_fault;
  logic              w_accept;
  logic              w_lost;
  logic              w_log_drop;

  // except alone (no access) is not a fault.
  assign w_fault  = (read | write) & except;
  assign w_accept = w_fault & (r_state == ST_IDLE);
  assign w_lost   = w_fault & (r_state != ST_IDLE);

  // Trap FSM with registered request/stall/flush and captured fault fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_trap_req   <= 1'b0;
      r_trap_cause <= 2'b00;
      r_trap_addr  <= {ADDR_W{1'b0}};
      r_trap_priv  <= 2'b00;
      r_stall      <= 1'b0;
      r_flush      <= 1'b0;
      r_count      <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_PENDING;
            r_trap_req   <= 1'b1;
            r_stall      <= 1'b1;
            r_trap_cause <= cause_of(write);
            r_trap_addr  <= address;
            r_trap_priv  <= priv_state;
            if (r_count != CNT_MAX) begin
              r_count <= r_count + CNT_ONE;
            end
          end
        end
        ST_PENDING: begin
          if (trap_ack) begin
            r_state    <= ST_FLUSH;
            r_trap_req <= 1'b0;
            r_flush    <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // stall is held through the flush cycle and released with it.
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_stall <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_trap_req <= 1'b0;
          r_stall    <= 1'b0;
          r_flush    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a lost fault or dropped log entry beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_lost | w_log_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign trap_req     = r_trap_req;
  assign trap_cause   = r_trap_cause;
  assign trap_addr    = r_trap_addr;
  assign trap_priv    = r_trap_priv;
  assign stall        = r_stall;
  assign flush        = r_flush;
  assign trap_overrun = r_overrun;
  assign trap_count   = r_count;

`ifdef CSR_TRAP_LOG_EN
  logic              w_log_valid;
  logic [ADDR_W-1:0] w_log_addr;
  logic              w_log_full;

  // The log records the same address that is captured into trap_addr.
  trap_log_fifo #(
    .DATA_W (ADDR_W),
    .DEPTH  (LOG_DEPTH)
  ) u_trap_log_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  (address),
    .i_pop   (log_pop),
    .o_valid (w_log_valid),
    .o_data  (w_log_addr),
    .o_full  (w_log_full),
    .o_drop  (w_log_drop)
  );

  assign log_valid = w_log_valid;
  assign log_addr  = w_log_addr;
  assign log_full  = w_log_full;
`else
  logic w_unused_log;

  assign w_unused_log = log_pop ^ (LOG_DEPTH == 0);
  assign w_log_drop   = 1'b0;
  assign log_valid    = 1'b0;
  assign log_addr     = {ADDR_W{1'b0}};
  assign log_full     = 1'b0;
`endif

endmodule
